// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment states, offset width.
package tmds_pkg;

   localparam int unsigned OFFSET_W = 4;
   localparam logic [OFFSET_W-1:0] OFFSET_MAX = 4'd9;

   // Control tokens indexed by {C1,C0}; the encoder emits the same words.
   localparam logic [9:0] TOKEN_C00 = 10'h354;
   localparam logic [9:0] TOKEN_C01 = 10'h0AB;
   localparam logic [9:0] TOKEN_C10 = 10'h154;
   localparam logic [9:0] TOKEN_C11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_CONFIRM,
      ST_LOCKED
   } align_state_t;

   // Bit offset advances 0..9 and wraps.
   function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
      return (off == OFFSET_MAX) ? '0 : off + 1'b1;
   endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Signal bundle of one TMDS channel decoder: serial-side word in, decoded stream out.
interface tmds_channel_decoder_if;
   import tmds_pkg::*;

   logic [9:0]          tmds_word;
   logic [7:0]          data;
   logic [1:0]          ctrl;
   logic                de;
   logic                locked;
   logic [OFFSET_W-1:0] offset;

   // Source of TMDS words, consumer of the decoded stream.
   modport master (
      output tmds_word,
      input  data, ctrl, de, locked, offset
   );

   // The decoder itself.
   modport slave (
      input  tmds_word,
      output data, ctrl, de, locked, offset
   );

endinterface

// File: rtl/tmds_word_decode.sv
// Combinational 10b->8b TMDS decode with control-token detection.
module tmds_word_decode
   import tmds_pkg::*;
(
   input  logic [9:0] i_word,
   output logic       o_is_token,
   output logic [1:0] o_ctrl,
   output logic [7:0] o_data
);

   logic [7:0] d;

   // Match the word against the four control tokens.
   always_comb begin
      o_is_token = 1'b1;
      o_ctrl     = 2'b00;
      case (i_word)
         TOKEN_C00: o_ctrl = 2'b00;
         TOKEN_C01: o_ctrl = 2'b01;
         TOKEN_C10: o_ctrl = 2'b10;
         TOKEN_C11: o_ctrl = 2'b11;
         default:   o_is_token = 1'b0;
      endcase
   end

   // Undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      d         = i_word[9] ? ~i_word[7:0] : i_word[7:0];
      o_data    = '0;
      o_data[0] = d[0];
      for (int unsigned i = 1; i < 8; i++) begin
         o_data[i] = i_word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment search/lock and registered decode.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int unsigned P_LOCK_TOKENS  = 8,
   parameter int unsigned P_SEARCH_WORDS = 2048,
   parameter int unsigned P_LOSS_WORDS   = 4096
) (
   input  logic                i_pixclk,
   input  logic                i_reset,
   input  logic [9:0]          i_tmds_word,
   output logic [7:0]          o_data,
   output logic [1:0]          o_ctrl,
   output logic                o_de,
   output logic                o_locked,
   output logic [OFFSET_W-1:0] o_offset
);

   localparam int unsigned WD_W   = (P_SEARCH_WORDS > 1) ? $clog2(P_SEARCH_WORDS) : 1;
   localparam int unsigned LOSS_W = (P_LOSS_WORDS > 1) ? $clog2(P_LOSS_WORDS) : 1;
   localparam int unsigned TOK_W  = $clog2(P_LOCK_TOKENS + 1);

   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(P_SEARCH_WORDS - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(P_LOSS_WORDS - 1);
   localparam logic [TOK_W-1:0]  TOK_LOCK  = TOK_W'(P_LOCK_TOKENS);

   // Alignment front end
   logic [9:0]  prev_word;
   logic        prev_vld;
   logic [19:0] window;
   logic [9:0]  aligned_d;
   logic [9:0]  aligned_q;
   logic        aligned_vld;

   // Decode of the captured aligned word
   logic        dec_is_token;
   logic [1:0]  dec_ctrl;
   logic [7:0]  dec_data;

   // Alignment FSM and counters
   align_state_t        state_q, state_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [TOK_W-1:0]    tok_q, tok_d;
   logic [TOK_W-1:0]    tok_inc;
   logic [LOSS_W-1:0]   loss_q, loss_d;

   // Output registers
   logic [7:0] data_q, data_d;
   logic [1:0] ctrl_q, ctrl_d;
   logic       de_q, de_d;
   logic       locked_q, locked_d;

   assign window    = {i_tmds_word, prev_word};
   assign aligned_d = window[{1'b0, offset_q} +: 10];
   assign tok_inc   = tok_q + 1'b1;

   tmds_word_decode u_decode (
      .i_word     (aligned_q),
      .o_is_token (dec_is_token),
      .o_ctrl     (dec_ctrl),
      .o_data     (dec_data)
   );

   // Capture the previous word and the aligned word; the valid flags keep
   // the zero words left by reset from being counted as channel input.
   always_ff @(posedge i_pixclk) begin
      if (i_reset) begin
         prev_word   <= '0;
         prev_vld    <= 1'b0;
         aligned_q   <= '0;
         aligned_vld <= 1'b0;
      end else begin
         prev_word   <= i_tmds_word;
         prev_vld    <= 1'b1;
         aligned_q   <= aligned_d;
         aligned_vld <= prev_vld;
      end
   end

   // Next state, counters and output values from the decoded aligned word.
   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      wd_d     = wd_q;
      tok_d    = tok_q;
      loss_d   = loss_q;

      if (aligned_vld) begin
         case (state_q)
            ST_SEARCH: begin
               if (dec_is_token) begin
                  state_d = ST_CONFIRM;
                  tok_d   = TOK_W'(1);
                  wd_d    = '0;
               end else if (wd_q == WD_LAST) begin
                  offset_d = next_offset(offset_q);
                  wd_d     = '0;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
            ST_CONFIRM: begin
               if (dec_is_token) begin
                  tok_d = tok_inc;
                  if (tok_inc == TOK_LOCK) begin
                     state_d = ST_LOCKED;
                     loss_d  = '0;
                  end
               end else begin
                  state_d = ST_SEARCH;
                  tok_d   = '0;
                  wd_d    = '0;
               end
            end
            ST_LOCKED: begin
               if (dec_is_token) begin
                  loss_d = '0;
               end else if (loss_q == LOSS_LAST) begin
                  state_d  = ST_SEARCH;
                  offset_d = next_offset(offset_q);
                  loss_d   = '0;
                  tok_d    = '0;
                  wd_d     = '0;
               end else begin
                  loss_d = loss_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_SEARCH;
               tok_d   = '0;
               wd_d    = '0;
               loss_d  = '0;
            end
         endcase
      end

      // Presentation follows the state being entered, so the locking token
      // already shows as locked and the word that loses lock does not.
      data_d   = '0;
      de_d     = 1'b0;
      ctrl_d   = ctrl_q;
      locked_d = (state_d == ST_LOCKED);
      if (aligned_vld && (state_d == ST_LOCKED)) begin
         if (dec_is_token) begin
            ctrl_d = dec_ctrl;
         end else begin
            de_d   = 1'b1;
            data_d = dec_data;
         end
      end
   end

   // Alignment state, counters and output registers.
   always_ff @(posedge i_pixclk) begin
      if (i_reset) begin
         state_q  <= ST_SEARCH;
         offset_q <= '0;
         wd_q     <= '0;
         tok_q    <= '0;
         loss_q   <= '0;
         data_q   <= '0;
         ctrl_q   <= '0;
         de_q     <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         wd_q     <= wd_d;
         tok_q    <= tok_d;
         loss_q   <= loss_d;
         data_q   <= data_d;
         ctrl_q   <= ctrl_d;
         de_q     <= de_d;
         locked_q <= locked_d;
      end
   end

   assign o_data   = data_q;
   assign o_ctrl   = ctrl_q;
   assign o_de     = de_q;
   assign o_locked = locked_q;
   assign o_offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: a bit-stream reference model
// predicts every output cycle; a monitor compares independently.
module tb_tmds_channel_decoder;
   import tmds_pkg::*;

   localparam int unsigned LOCK_N   = 8;
   localparam int unsigned SEARCH_N = 4;
   localparam int unsigned LOSS_N   = 16;

   localparam int M_SEARCH  = 0;
   localparam int M_CONFIRM = 1;
   localparam int M_LOCKED  = 2;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] ctrl;
      logic       de;
      logic       locked;
      logic [3:0] off;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   tmds_channel_decoder_if bus ();

   tmds_channel_decoder #(
      .P_LOCK_TOKENS  (LOCK_N),
      .P_SEARCH_WORDS (SEARCH_N),
      .P_LOSS_WORDS   (LOSS_N)
   ) dut (
      .i_pixclk    (clk),
      .i_reset     (rst),
      .i_tmds_word (bus.tmds_word),
      .o_data      (bus.data),
      .o_ctrl      (bus.ctrl),
      .o_de        (bus.de),
      .o_locked    (bus.locked),
      .o_offset    (bus.offset)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   obs_t       exp_q[$];
   logic [7:0] byte_q[$];
   bit         lb_active = 1'b0;
   logic       bitq[$];

   // Reference model state: a bit-level view of the channel.
   int         m_state, m_off, m_wd, m_cnt, m_loss;
   logic [9:0] m_prev, m_al;
   bit         m_prev_vld, m_al_vld;
   obs_t       m_out;

   function automatic void ref_dec(input logic [9:0] q, output logic tok,
                                   output logic [1:0] c, output logic [7:0] dd);
      logic [7:0] d;
      tok = 1'b1;
      c   = 2'b00;
      case (q)
         10'h354: c = 2'b00;
         10'h0AB: c = 2'b01;
         10'h154: c = 2'b10;
         10'h2AB: c = 2'b11;
         default: tok = 1'b0;
      endcase
      d  = q[9] ? ~q[7:0] : q[7:0];
      dd = d ^ {d[6:0], 1'b0};
      if (!q[8]) dd[7:1] = ~dd[7:1];
   endfunction

   // Transition-minimising encoder; inv chooses the optional inversion.
   function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
      logic [7:0] qm;
      int n1;
      logic use_xnor;
      n1 = $countones(b);
      use_xnor = (n1 > 4) || (n1 == 4 && !b[0]);
      qm[0] = b[0];
      for (int i = 1; i < 8; i++)
         qm[i] = use_xnor ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
      return {inv, ~use_xnor, inv ? ~qm : qm};
   endfunction

   task automatic model_step(input logic [9:0] w, input logic r);
      logic [19:0] win;
      logic [9:0]  nal;
      logic        tok;
      logic [1:0]  c;
      logic [7:0]  dd;
      if (r) begin
         m_state = M_SEARCH; m_off = 0; m_wd = 0; m_cnt = 0; m_loss = 0;
         m_prev = '0; m_al = '0; m_prev_vld = 0; m_al_vld = 0;
         m_out = '0;
      end else begin
         win = {w, m_prev};
         win = win >> m_off;
         nal = win[9:0];
         m_out.de   = 1'b0;
         m_out.data = '0;
         if (m_al_vld) begin
            ref_dec(m_al, tok, c, dd);
            if (m_state == M_SEARCH) begin
               if (tok) begin m_state = M_CONFIRM; m_cnt = 1; m_wd = 0; end
               else if (m_wd == SEARCH_N - 1) begin m_off = (m_off + 1) % 10; m_wd = 0; end
               else m_wd++;
            end else if (m_state == M_CONFIRM) begin
               if (tok) begin
                  m_cnt++;
                  if (m_cnt == LOCK_N) begin m_state = M_LOCKED; m_loss = 0; end
               end else begin m_state = M_SEARCH; m_cnt = 0; m_wd = 0; end
            end else begin
               if (tok) m_loss = 0;
               else if (m_loss == LOSS_N - 1) begin
                  m_state = M_SEARCH; m_off = (m_off + 1) % 10;
                  m_loss = 0; m_cnt = 0; m_wd = 0;
               end else m_loss++;
            end
            if (m_state == M_LOCKED) begin
               if (tok) m_out.ctrl = c;
               else begin m_out.de = 1'b1; m_out.data = dd; end
            end
         end
         m_out.locked = (m_state == M_LOCKED);
         m_out.off    = 4'(m_off);
         m_al = nal; m_al_vld = m_prev_vld; m_prev = w; m_prev_vld = 1'b1;
      end
      exp_q.push_back(m_out);
   endtask

   task automatic drive(input logic [9:0] w, input logic r);
      @(negedge clk);
      bus.tmds_word = w;
      rst = r;
      model_step(w, r);
   endtask

   task automatic do_reset(input int n);
      bitq.delete();
      repeat (n) drive(10'($urandom), 1'b1);
   endtask

   task automatic put_bit(input logic b);
      logic [9:0] w;
      bitq.push_back(b);
      if (bitq.size() >= 10) begin
         for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
         drive(w, 1'b0);
      end
   endtask

   task automatic put_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) put_bit(s[i]);
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic settle_check(input string name, input logic [15:0] want_lock_off_ctrl);
      @(posedge clk); #2;
      check(name, {9'd0, bus.locked, bus.offset, bus.ctrl}, want_lock_off_ctrl);
   endtask

   // Monitor: compare every output cycle against the scoreboard.
   initial begin
      obs_t e, g;
      forever begin
         @(posedge clk); #1;
         g = '{data: bus.data, ctrl: bus.ctrl, de: bus.de, locked: bus.locked, off: bus.offset};
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (g !== e) begin
               mismatched++;
               $display("FAIL stream @%0t: got data=%h ctrl=%b de=%b lock=%b off=%0d want data=%h ctrl=%b de=%b lock=%b off=%0d",
                        $time, g.data, g.ctrl, g.de, g.locked, g.off, e.data, e.ctrl, e.de, e.locked, e.off);
            end
         end
         if (lb_active && g.de === 1'b1) begin
            compared++;
            if (byte_q.size() == 0) begin
               mismatched++;
               $display("FAIL loopback: got byte %h want none", g.data);
            end else if (g.data !== byte_q[0]) begin
               mismatched++;
               $display("FAIL loopback: got byte %h want %h", g.data, byte_q[0]);
               void'(byte_q.pop_front());
            end else begin
               void'(byte_q.pop_front());
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] toks[4];
      logic [7:0] b;
      toks[0] = TOKEN_C00; toks[1] = TOKEN_C01; toks[2] = TOKEN_C10; toks[3] = TOKEN_C11;
      bus.tmds_word = '0;

      // Reset state
      do_reset(3);
      @(posedge clk); #2;
      check("reset_state", {bus.data, bus.ctrl, bus.de, bus.locked, bus.offset}, 16'h0000);

      // Offset-0 lock and first data word
      do_reset(2);
      repeat (20) put_sym(TOKEN_C00);
      put_sym(10'h100);
      put_sym(TOKEN_C00);
      put_sym(TOKEN_C00);
      @(posedge clk); #2;
      check("off0_data", {bus.data, bus.ctrl, bus.de, bus.locked, bus.offset}, {8'h00, 2'b00, 1'b1, 1'b1, 4'd0});

      // Confirm aborted by a data word
      do_reset(2);
      repeat (5) put_sym(TOKEN_C00);
      put_sym(10'h100);
      put_sym(10'h100);
      put_sym(10'h100);
      settle_check("confirm_abort", {9'd0, 1'b0, 4'd0, 2'b00});

      // Stream shifted by 3 bits
      do_reset(2);
      repeat (3) put_bit(1'b0);
      repeat (40) put_sym(TOKEN_C01);
      settle_check("shift3_lock", {9'd0, 1'b1, 4'd3, 2'b01});

      // Lock at offset 7, then reset while locked
      do_reset(2);
      repeat (7) put_bit(1'b0);
      repeat (60) put_sym(TOKEN_C11);
      repeat (5) put_sym(enc(8'($urandom), 1'($urandom)));
      settle_check("shift7_lock", {9'd0, 1'b1, 4'd7, 2'b11});
      drive(10'($urandom), 1'b1);
      @(posedge clk); #2;
      check("reset_locked", {7'd0, bus.de, bus.locked, bus.offset, bus.ctrl}, 16'h0000);

      // Loss of lock after LOSS_N data words
      do_reset(1);
      repeat (12) put_sym(TOKEN_C10);
      repeat (LOSS_N + 2) put_sym(enc(8'($urandom), 1'($urandom)));
      settle_check("loss_of_lock", {9'd0, 1'b0, 4'd1, 2'b10});

      // Encoder loopback over every byte value, 12 per line, 12-token blanking
      do_reset(2);
      repeat (20) put_sym(TOKEN_C00);
      lb_active = 1'b1;
      for (int v = 0; v < 256; v++) begin
         b = 8'(v);
         byte_q.push_back(b);
         put_sym(enc(b, 1'($urandom)));
         if (v % 12 == 11 || v == 255) repeat (12) put_sym(toks[$urandom_range(0, 3)]);
      end
      repeat (3) drive(TOKEN_C00, 1'b0);
      @(posedge clk); #2;
      lb_active = 1'b0;
      check("loopback_drained", 16'(byte_q.size()), 16'd0);

      // Randomised streams with random bit offsets, glitches and resets
      for (int seg = 0; seg < 8; seg++) begin
         do_reset($urandom_range(1, 2));
         repeat ($urandom_range(0, 9)) put_bit(1'($urandom));
         for (int s = 0; s < 60; s++) begin
            logic [9:0] t;
            t = toks[$urandom_range(0, 3)];
            repeat ($urandom_range(1, 12)) put_sym(t);
            repeat ($urandom_range(1, 20)) put_sym(enc(8'($urandom), 1'($urandom)));
            if ($urandom_range(0, 19) == 0) put_sym(10'($urandom));
            if ($urandom_range(0, 59) == 0) do_reset(1);
         end
      end

      repeat (2) drive(TOKEN_C00, 1'b0);
      @(posedge clk); #2;
      check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/tmds_channel_decoder.md
TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter P_LOCK_TOKENS, default 8: number of consecutive control tokens at one bit offset required to declare lock.
REQ-002 SHALL have parameter P_SEARCH_WORDS, default 2048: number of words in SEARCH without any control token before the bit offset advances.
REQ-003 SHALL have parameter P_LOSS_WORDS, default 4096: number of words in LOCKED without any control token before lock is dropped.
REQ-004 SHALL have port i_pixclk, input, 1 bit: the single clock; one 10-bit TMDS word per cycle.
REQ-005 SHALL have port i_reset, input, 1 bit: synchronous reset, active-high.
REQ-006 SHALL have port i_tmds_word, input, 10 bits: deserialized channel word; bit 0 is the first bit on the wire, and word boundaries are arbitrary.
REQ-007 SHALL have port o_data, output, 8 bits: decoded pixel byte.
REQ-008 SHALL have port o_ctrl, output, 2 bits: decoded {C1,C0}, held from the last control token.
REQ-009 SHALL have port o_de, output, 1 bit: data enable; 1 = o_data valid.
REQ-010 SHALL have port o_locked, output, 1 bit: word alignment achieved.
REQ-011 SHALL have port o_offset, output, 4 bits: current bit offset, range 0..9.

Function
REQ-012 SHALL keep the previous input word and form the 20-bit window {i_tmds_word, prev_word}; the aligned word SHALL be window[offset+9 : offset].
REQ-013 SHALL recognise exactly four control tokens: 10'h354 -> ctrl 00, 10'h0AB -> 01, 10'h154 -> 10, 10'h2AB -> 11.
REQ-014 SHALL decode a non-token word q as follows: d = q[9] ? ~q[7:0] : q[7:0]; D[0] = d[0]; for i = 1..7, D[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-015 SHALL implement three states: SEARCH, CONFIRM and LOCKED.
REQ-016 In SEARCH, a token SHALL cause a move to CONFIRM with token count = 1.
REQ-017 In SEARCH, a non-token word SHALL increment the watchdog count.
REQ-018 In SEARCH, when the watchdog reaches P_SEARCH_WORDS-1 with no token, offset SHALL advance by 1 (9 wraps to 0) and the watchdog SHALL clear.
REQ-019 In CONFIRM, a token SHALL increment the token count; on reaching P_LOCK_TOKENS the state SHALL move to LOCKED.
REQ-020 In CONFIRM, a non-token word SHALL return the state to SEARCH with the offset unchanged and the counts cleared.
REQ-021 In LOCKED, any token SHALL clear the loss counter and a non-token word SHALL increment it.
REQ-022 When the loss counter reaches P_LOSS_WORDS-1, the state SHALL go to SEARCH, offset SHALL advance by 1 and o_locked SHALL drop on the next cycle.
REQ-023 o_locked SHALL be 1 exactly while the state is LOCKED.
REQ-024 While LOCKED, a token SHALL give o_de=0, o_ctrl=token value and o_data=0.
REQ-025 While LOCKED, a data word SHALL give o_de=1 and o_data=D, with o_ctrl held.
REQ-026 While not LOCKED, o_de SHALL be 0 and o_data SHALL be 0, with o_ctrl held at its last value.
REQ-027 All outputs SHALL be registered.
REQ-028 Latency SHALL be 2 cycles from the i_pixclk edge that samples the input word carrying the last bit of an aligned word to the edge on which its decode appears.
REQ-029 Entering LOCKED SHALL take effect on the cycle after the P_LOCK_TOKENS-th token; that token itself SHALL already be presented with o_locked=1.
REQ-030 An offset change SHALL take effect on the next window, without flushing the pipeline; the first word after a change is don't-care for checking.

Reset
REQ-031 On i_reset=1 at a clock edge, the block SHALL set: state SEARCH, offset 0, all counters 0, prev_word 0, o_data 0, o_ctrl 00, o_de 0, o_locked 0, o_offset 0.
REQ-032 Reset SHALL win over every simultaneous event, including mid-lock and mid-search, and the first word after reset release SHALL be treated as a fresh SEARCH input.

Structure
REQ-033 A shared package (tmds_pkg) SHALL hold the four token constants, the state enumeration and the 4-bit offset width; the existing encoder SHALL use the same token constants.
REQ-034 The pure-combinational 10b->8b decode and token detect SHALL be a sub-module, tmds_word_decode; the alignment FSM, counters and output registers SHALL stay in tmds_channel_decoder.

Verification
REQ-035 Offset-0 stream: 20 x 10'h354 then data word 10'h100 -> o_locked=1 after token 8 + latency; data decodes to o_data=8'h00, o_de=1.
REQ-036 Stream shifted by 3 bits, 40 tokens (P_SEARCH_WORDS set to 4 for the bench) -> o_offset steps 0,1,2,3 and stops at 3; o_locked=1; o_ctrl=01 for a 10'h0AB run.
REQ-037 Encoder loopback: tmds_encoder output for bytes 0x00..0xFF, with blanking of 12 tokens per line -> every byte recovered, o_de matches encoder DE delayed by the fixed pipeline.
REQ-038 In CONFIRM, 5 tokens then 1 data word -> state returns to SEARCH, o_locked stays 0, o_offset unchanged.
REQ-039 Locked stream followed by P_LOSS_WORDS data words with no tokens -> o_locked falls to 0 and o_offset increments by 1.
REQ-040 i_reset asserted for 1 cycle while LOCKED at offset 7 -> next cycle: o_locked=0, o_offset=0, o_de=0, o_ctrl=00.
